// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one WIDTH-bit ALU between two valid/ready requesters
// (0 = EX-stage integer path, 1 = branch/address helper). One transaction is
// in flight at a time: IDLE (arbitrate/accept) -> EXEC (ALU evaluates latched
// operands) -> RESP (hold captured result until the addressed requester takes it).
// Optional macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins a tie instead
// of round-robin; the last-grant pointer is then removed.
module alu_share_arb #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic [OPW-1:0]   req1_op,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_carry,
    output logic             resp_ovf,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OPW-1:0]   op_q;
    logic             id_q;
    logic             grant;
    logic             accept;
    logic             resp_done;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic             last_q;
`endif

    // Arbitration: pick the requester to offer ready to in IDLE
    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant = ~req_valid[0];
`else
        if (&req_valid) begin
            grant = ~last_q;
        end else begin
            grant = ~req_valid[0];
        end
`endif
    end

    assign accept    = (state == IDLE) && req_valid[grant];
    assign resp_done = (state == RESP) && resp_ready[id_q];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req_valid[grant]) begin
                    req_ready[grant] = 1'b1;
                    state_nxt        = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid[id_q] = 1'b1;
                if (resp_ready[id_q]) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch on accept; ALU inputs come only from these registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            id_q <= 1'b0;
        end else if (accept) begin
            a_q  <= grant ? req1_a  : req0_a;
            b_q  <= grant ? req1_b  : req0_b;
            op_q <= grant ? req1_op : req0_op;
            id_q <= grant;
        end
    end

    // Capture ALU result and flags at the end of EXEC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_carry  <= 1'b0;
            resp_ovf    <= 1'b0;
        end else if (state == EXEC) begin
            resp_result <= alu_result;
            resp_zero   <= alu_zero;
            resp_carry  <= alu_carry;
            resp_ovf    <= alu_ovf;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Last-grant pointer: reset to 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (resp_done) begin
            last_q <= id_q;
        end
    end
`endif

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;

endmodule
